// File: rtl/mac_sequencer.sv
// mac_sequencer: operand-side controller that feeds a dot-product job into an external 16x16 MAC ALU.
// Ports:
//   clk, R_n (async active-low reset)
//   start, len                  job request, length latched on acceptance; busy high outside IDLE
//   op_valid/op_ready, op_x/op_b upstream operand pair stream
//   alu_X/alu_B/alu_valid_in/alu_R registered ALU drive; alu_y ALU accumulator readback
//   res_valid/res_ready/res_data captured accumulator result
module mac_sequencer #(
    parameter int LEN_W  = 8,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 39
) (
    input  logic              clk,
    input  logic              R_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [DATA_W-1:0] op_x,
    input  logic [DATA_W-1:0] op_b,
    output logic [DATA_W-1:0] alu_X,
    output logic [DATA_W-1:0] alu_B,
    output logic              alu_valid_in,
    output logic              alu_R,
    input  logic [ACC_W-1:0]  alu_y,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res_data
);
    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, CAPTURE, DONE} state_t;
    state_t state, state_nx;
    logic [LEN_W-1:0] len_q, cnt;
    logic accept, hs, last;
    always_comb begin
        state_nx = state;
        busy     = state != IDLE;
        op_ready = state == FEED;
        accept   = state == IDLE && start;
        hs       = op_ready && op_valid;
        last     = cnt == len_q - LEN_W'(1);
        unique case (state)
            IDLE:    state_nx = start ? CLEAR : IDLE;
            CLEAR:   state_nx = len_q != '0 ? FEED : CAPTURE;
            FEED:    state_nx = hs && last ? DRAIN : FEED;
            DRAIN:   state_nx = CAPTURE;
            CAPTURE: state_nx = DONE;
            DONE:    state_nx = res_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end
    // alu_R resets high so the ALU accumulator is also cleared while R_n is held low.
    always_ff @(posedge clk or negedge R_n) begin
        if (!R_n) begin
            state        <= IDLE;
            len_q        <= '0;
            cnt          <= '0;
            alu_X        <= '0;
            alu_B        <= '0;
            alu_valid_in <= 1'b0;
            alu_R        <= 1'b1;
            res_valid    <= 1'b0;
            res_data     <= '0;
        end else begin
            state        <= state_nx;
            alu_R        <= accept;
            alu_valid_in <= hs;
            if (accept) begin
                len_q <= len;
                cnt   <= '0;
            end
            if (hs) begin
                alu_X <= op_x;
                alu_B <= op_b;
                cnt   <= cnt + LEN_W'(1);
            end
            // One cycle after DRAIN the ALU has folded in the last pair, so alu_y is final here.
            if (state == CAPTURE) begin
                res_data  <= alu_y;
                res_valid <= 1'b1;
            end
            if (state == DONE && res_ready) res_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mac_sequencer.sv
// tb_mac_sequencer: randomized self-checking bench for mac_sequencer with a behavioural MAC ALU.
module tb_mac_sequencer;
    localparam int LEN_W = 8, DATA_W = 16, ACC_W = 39;
    logic              clk = 0, R_n = 0, start = 0, op_valid = 0, res_ready = 0;
    logic [LEN_W-1:0]  len = '0;
    logic [DATA_W-1:0] op_x = '0, op_b = '0, alu_X, alu_B;
    logic              busy, op_ready, alu_valid_in, alu_R, res_valid;
    logic [ACC_W-1:0]  alu_y = '0, res_data;
    int total = 0, bad = 0, cyc = 0;
    logic [DATA_W-1:0] jx[256], jb[256];
    int jg[256];
    logic jpoke = 0;

    mac_sequencer #(.LEN_W(LEN_W), .DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .R_n(R_n), .start(start), .len(len), .busy(busy),
        .op_valid(op_valid), .op_ready(op_ready), .op_x(op_x), .op_b(op_b),
        .alu_X(alu_X), .alu_B(alu_B), .alu_valid_in(alu_valid_in), .alu_R(alu_R),
        .alu_y(alu_y), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Team ALU: unsigned 32-bit product, sign-extended from bit 31 into the accumulator.
    logic [31:0] prod;
    assign prod = alu_X * alu_B;
    always @(posedge clk)
        alu_y <= alu_R ? '0 : alu_valid_in ? alu_y + {{(ACC_W-32){prod[31]}}, prod} : alu_y;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [ACC_W-1:0] ref_sum(input int n);
        logic [ACC_W-1:0] acc = '0;
        logic [31:0] p;
        for (int k = 0; k < n; k++) begin
            p = jx[k] * jb[k];
            acc = acc + ACC_W'($signed(p));
        end
        return acc;
    endfunction

    function automatic int gap_sum(input int n);
        int s = 0;
        for (int k = 0; k < n; k++) s += jg[k];
        return s;
    endfunction

    task automatic clear_job;
        for (int k = 0; k < 256; k++) begin
            jx[k] = '0; jb[k] = '0; jg[k] = 0;
        end
        jpoke = 0;
    endtask

    // Drives one job and reports the result, the start-to-res_valid latency and protocol violations.
    task automatic do_job(input int n, input int hold, output logic [ACC_W-1:0] d, output int lat, output int viol);
        int w;
        int t0;
        viol = 0; lat = -1; d = '0;
        len = LEN_W'(n); start = 1; res_ready = 0;
        tick;
        start = 0; t0 = cyc;
        if (alu_R !== 1'b1 || busy !== 1'b1) viol++;
        for (int k = 0; k < n; k++) begin
            for (int g = 0; g < jg[k]; g++) begin
                op_valid = 0;
                if (jpoke) begin start = 1; len = ~LEN_W'(n); end
                tick;
                start = 0;
                if (alu_valid_in !== 1'b0 || op_ready !== 1'b1) viol++;
            end
            op_valid = 1; op_x = jx[k]; op_b = jb[k];
            w = 0;
            while (op_ready !== 1'b1 && w < 20) begin tick; w++; end
            tick;
            if (alu_valid_in !== 1'b1 || alu_X !== jx[k] || alu_B !== jb[k]) viol++;
            op_valid = 0; op_x = DATA_W'($urandom); op_b = DATA_W'($urandom);
        end
        w = 0;
        while (res_valid !== 1'b1 && w < 1000) begin tick; w++; end
        if (res_valid === 1'b1) begin
            lat = cyc - t0;
            d = res_data;
            repeat (hold) begin
                tick;
                if (res_valid !== 1'b1 || res_data !== d || busy !== 1'b1) viol++;
            end
            res_ready = 1;
            tick;
            res_ready = 0;
            if (res_valid !== 1'b0 || busy !== 1'b0 || res_data !== d) viol++;
        end
    endtask

    task automatic test_reset;
        R_n = 0;
        repeat (3) tick;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (op_ready !== 1'b0) begin bad++; $display("FAIL reset_op_ready got=%b want=0", op_ready); end
        total++; if (alu_valid_in !== 1'b0) begin bad++; $display("FAIL reset_valid_in got=%b want=0", alu_valid_in); end
        total++; if (alu_X !== '0 || alu_B !== '0) begin bad++; $display("FAIL reset_operands got=%h/%h want=0/0", alu_X, alu_B); end
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL reset_res_valid got=%b want=0", res_valid); end
        total++; if (res_data !== '0) begin bad++; $display("FAIL reset_res_data got=%h want=0", res_data); end
        total++; if (alu_R !== 1'b1) begin bad++; $display("FAIL reset_alu_R got=%b want=1", alu_R); end
        #2 R_n = 1;
        tick;
        total++; if (alu_R !== 1'b0) begin bad++; $display("FAIL reset_release_alu_R got=%b want=0", alu_R); end
    endtask

    task automatic test_basic;
        logic [ACC_W-1:0] d; int lat, viol;
        clear_job;
        jx[0] = 2; jb[0] = 3; jx[1] = 4; jb[1] = 5; jx[2] = 6; jb[2] = 7;
        do_job(3, 0, d, lat, viol);
        total++; if (d !== 39'd68) begin bad++; $display("FAIL basic_data got=%0d want=68", d); end
        total++; if (lat !== 6) begin bad++; $display("FAIL basic_latency got=%0d want=6", lat); end
        total++; if (viol !== 0) begin bad++; $display("FAIL basic_protocol got=%0d want=0", viol); end
    endtask

    task automatic test_stall;
        logic [ACC_W-1:0] d; int lat, viol;
        clear_job;
        jx[0] = 2; jb[0] = 3; jx[1] = 4; jb[1] = 5; jx[2] = 6; jb[2] = 7; jg[1] = 2;
        do_job(3, 0, d, lat, viol);
        total++; if (d !== 39'd68) begin bad++; $display("FAIL stall_data got=%0d want=68", d); end
        total++; if (lat !== 8) begin bad++; $display("FAIL stall_latency got=%0d want=8", lat); end
        total++; if (viol !== 0) begin bad++; $display("FAIL stall_protocol got=%0d want=0", viol); end
    endtask

    task automatic test_sign;
        logic [ACC_W-1:0] d; int lat, viol;
        clear_job;
        jx[0] = 16'hFFFF; jb[0] = 16'hFFFF;
        do_job(1, 0, d, lat, viol);
        total++; if (d !== 39'h7FFFFE0001) begin bad++; $display("FAIL sign_data got=%h want=7ffffe0001", d); end
        total++; if (lat !== 4) begin bad++; $display("FAIL sign_latency got=%0d want=4", lat); end
    endtask

    task automatic test_back_to_back;
        logic [ACC_W-1:0] d, e; int lat, viol;
        clear_job;
        jx[0] = DATA_W'($urandom); jb[0] = DATA_W'($urandom);
        jx[1] = DATA_W'($urandom); jb[1] = DATA_W'($urandom);
        e = ref_sum(2);
        do_job(2, 5, d, lat, viol);
        total++; if (d !== e) begin bad++; $display("FAIL backpressure_data got=%h want=%h", d, e); end
        total++; if (viol !== 0) begin bad++; $display("FAIL backpressure_stable got=%0d want=0", viol); end
        clear_job;
        jx[0] = 1; jb[0] = 1; jx[1] = 1; jb[1] = 1;
        do_job(2, 0, d, lat, viol);
        total++; if (d !== 39'd2) begin bad++; $display("FAIL back_to_back_data got=%0d want=2", d); end
        total++; if (lat !== 5) begin bad++; $display("FAIL back_to_back_latency got=%0d want=5", lat); end
    endtask

    task automatic test_len_zero_and_start_busy;
        logic [ACC_W-1:0] d, e; int lat, viol;
        clear_job;
        do_job(0, 0, d, lat, viol);
        total++; if (d !== '0) begin bad++; $display("FAIL len0_data got=%h want=0", d); end
        total++; if (lat !== 2) begin bad++; $display("FAIL len0_latency got=%0d want=2", lat); end
        total++; if (viol !== 0) begin bad++; $display("FAIL len0_protocol got=%0d want=0", viol); end
        clear_job;
        for (int k = 0; k < 3; k++) begin jx[k] = DATA_W'($urandom); jb[k] = DATA_W'($urandom); end
        jg[1] = 2; jpoke = 1;
        e = ref_sum(3);
        do_job(3, 0, d, lat, viol);
        total++; if (d !== e) begin bad++; $display("FAIL start_busy_data got=%h want=%h", d, e); end
        total++; if (lat !== 8) begin bad++; $display("FAIL start_busy_latency got=%0d want=8", lat); end
        jpoke = 0;
    endtask

    task automatic test_reset_mid_feed;
        logic [ACC_W-1:0] d; int lat, viol;
        len = 3; start = 1;
        tick;
        start = 0;
        tick;
        op_valid = 1; op_x = 5; op_b = 5;
        tick;
        op_valid = 0;
        #2 R_n = 0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%b want=0", busy); end
        total++; if (op_ready !== 1'b0) begin bad++; $display("FAIL midreset_op_ready got=%b want=0", op_ready); end
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL midreset_res_valid got=%b want=0", res_valid); end
        total++; if (alu_R !== 1'b1) begin bad++; $display("FAIL midreset_alu_R got=%b want=1", alu_R); end
        total++; if (alu_valid_in !== 1'b0 || alu_X !== '0) begin bad++; $display("FAIL midreset_alu got=%b/%h want=0/0", alu_valid_in, alu_X); end
        tick;
        R_n = 1;
        tick;
        clear_job;
        jx[0] = 3; jb[0] = 3;
        do_job(1, 0, d, lat, viol);
        total++; if (d !== 39'd9) begin bad++; $display("FAIL after_reset_data got=%0d want=9", d); end
        total++; if (lat !== 4) begin bad++; $display("FAIL after_reset_latency got=%0d want=4", lat); end
    endtask

    task automatic test_random;
        logic [ACC_W-1:0] d, e; int lat, viol, n, h, el;
        for (int j = 0; j < 20; j++) begin
            clear_job;
            n = $urandom_range(1, 12);
            h = $urandom_range(0, 3);
            for (int k = 0; k < n; k++) begin
                jx[k] = DATA_W'($urandom); jb[k] = DATA_W'($urandom);
                jg[k] = k == 0 ? 0 : $urandom_range(0, 2);
            end
            e = ref_sum(n);
            el = n + 3 + gap_sum(n);
            do_job(n, h, d, lat, viol);
            total++; if (d !== e) begin bad++; $display("FAIL random_data job=%0d got=%h want=%h", j, d, e); end
            total++; if (lat !== el) begin bad++; $display("FAIL random_latency job=%0d got=%0d want=%0d", j, lat, el); end
            total++; if (viol !== 0) begin bad++; $display("FAIL random_protocol job=%0d got=%0d want=0", j, viol); end
        end
    endtask

    task automatic test_max_len;
        logic [ACC_W-1:0] d, e; int lat, viol;
        clear_job;
        for (int k = 0; k < 255; k++) begin jx[k] = DATA_W'($urandom); jb[k] = DATA_W'($urandom); end
        e = ref_sum(255);
        do_job(255, 0, d, lat, viol);
        total++; if (d !== e) begin bad++; $display("FAIL maxlen_data got=%h want=%h", d, e); end
        total++; if (lat !== 258) begin bad++; $display("FAIL maxlen_latency got=%0d want=258", lat); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_stall;
        test_sign;
        test_back_to_back;
        test_len_zero_and_start_busy;
        test_reset_mid_feed;
        test_random;
        test_max_len;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mac_sequencer.md
# mac_sequencer

Operand-side controller for the team's 16×16 multiply-accumulate ALU. It accepts a dot-product job of `len` operand pairs and pulls pairs from an upstream valid/ready stream. It drives the ALU's `X`/`B`/`valid_in`/`R` inputs, clears the accumulator before each job and captures the final 39-bit accumulator into a valid/ready result port. It sits between the operand buffers and the ALU, and the ALU is instantiated outside this block.

## Interface
Parameters:
- `LEN_W`, default 8, width of the job length field; maximum job is 2^LEN_W−1 pairs.
- `DATA_W`, default 16, operand width; must match the ALU operand width.
- `ACC_W`, default 39, accumulator width; must match the ALU `y` width.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `R_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  job request; sampled only in IDLE.
- `len`  in  LEN_W  number of operand pairs; latched when `start` is accepted.
- `busy`  out  1  high whenever state ≠ IDLE.
- `op_valid`  in  1  upstream operand pair valid.
- `op_ready`  out  1  block accepts a pair this cycle.
- `op_x`, `op_b`  in  DATA_W  operand pair.
- `alu_X`, `alu_B`  out  DATA_W  registered operands to the ALU.
- `alu_valid_in`  out  1  registered; ALU accumulates at the next edge.
- `alu_R`  out  1  registered; ALU accumulator clear (the ALU clears synchronously).
- `alu_y`  in  ACC_W  ALU accumulator output.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  downstream accepts the result.
- `res_data`  out  ACC_W  captured accumulator value.

## Operation
- The FSM has six states: IDLE, CLEAR, FEED, DRAIN, CAPTURE and DONE.
- **IDLE:** `start`=1 moves the FSM to CLEAR and latches `len` into `len_q` with `cnt`=0. `alu_R` is registered to 1 for exactly the CLEAR cycle.
- **CLEAR:** one cycle only.
  - Next state is FEED if `len_q`≠0.
  - Next state is CAPTURE if `len_q`=0, which yields a result of 0.
- **FEED:** `op_ready`=1.
  - On a handshake (`op_valid`&`op_ready`), `alu_X`/`alu_B` are loaded with `op_x`/`op_b`, `alu_valid_in` is set to 1 and `cnt` increments.
  - Without a handshake, `alu_valid_in` is set to 0 and `alu_X`/`alu_B` hold their values.
  - A handshake with `cnt`=`len_q`−1 moves the FSM to DRAIN.
- **DRAIN:** one cycle. `op_ready`=0 and the last pair is on the ALU inputs. At the edge the FSM moves to CAPTURE and `alu_valid_in` is set to 0.
- **CAPTURE:** one cycle. `alu_y` now holds the final sum. At the edge, `res_data` is loaded with `alu_y`, `res_valid` is set to 1 and the FSM moves to DONE.
- **DONE:** `res_valid` and `res_data` are held stable until `res_ready`=1. On that edge `res_valid` drops to 0 and the FSM moves to IDLE.
  - `res_data` holds its value after the handshake.
- `start` is ignored while `busy`=1, with no effect and no queuing.
- `op_ready`=0 in every state other than FEED.
- `op_valid` gaps in FEED stall the job indefinitely with no timeout.
- No arithmetic is done in this block. `res_data` is the ALU's value bit-for-bit, including its sign extension of product bit 31.

## Timing
- **Reset values** (while `R_n`=0, asynchronous):
  - state = IDLE; `cnt`, `len_q` = 0.
  - `busy`=0, `op_ready`=0, `alu_valid_in`=0.
  - `alu_X`=`alu_B`=0, `res_valid`=0, `res_data`=0.
  - `alu_R`=1, so the ALU is cleared during reset; it is registered to 0 at the first edge after release.
- **Reset mid-job:** the job is abandoned and all outputs take their reset values immediately. No partial result is ever presented.
- **Latency**, with `start` accepted at edge t and `op_valid` held at 1:
  - handshakes occur at edges t+2 … t+N+1;
  - `res_valid` rises at edge t+N+3.
  - Each cycle of `op_valid`=0 in FEED adds one cycle.
  - For `len`=0, `res_valid` rises at t+2 with `res_data`=0.
- **Back-to-back jobs:** earliest next `start` acceptance is the edge after the DONE handshake, because IDLE must be visited.
- **ALU contract:** the ALU samples `alu_X`/`alu_B`/`alu_valid_in` on the same edge that it updates `y`. Pair k is therefore included in `alu_y` one cycle after it appears on `alu_X`/`alu_B`.

## Test plan
The bench instantiates this block with the team ALU and checks the following scenarios.
- **Basic job:** `len`=3, pairs (2,3),(4,5),(6,7), `op_valid` continuous, `res_ready`=1 → `res_data`=68; `res_valid` rises exactly 6 edges after `start`.
- **Stalled stream:** same job with `op_valid` low for 2 cycles between pairs 1 and 2 → `res_data`=68; `res_valid` is 2 cycles later than in the basic job; `alu_valid_in`=0 during the gap.
- **Sign-extension pass-through:** `len`=1, pair (0xFFFF,0xFFFF) → `res_data`=0x7FFFFE0001.
- **Result backpressure and back-to-back jobs:** `res_ready`=0 for 5 cycles → `res_valid`/`res_data` stable and `busy`=1. After the handshake, a second job (1,1)×2 returns 2, confirming the accumulator was cleared.
- **Length-zero job and `start` while busy:** `len`=0 → `res_data`=0 at t+2. A `start` pulse during FEED changes neither `len_q` nor the result.
- **Reset mid-FEED:** `R_n` low after 1 of 3 pairs → `busy`, `op_ready` and `res_valid` go to 0 immediately and `alu_R`=1. A subsequent `len`=1 job (3,3) returns 9.
